// File: rtl/blob_motion_ctrl_pkg.sv
// Shared display constants, sprite mode encoding and per-axis motion helpers.
// Pure combinational helpers; no state, no flow control.
package blob_motion_ctrl_pkg;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;

   localparam logic [1:0] MODE_BOUNCE = 2'd0;
   localparam logic [1:0] MODE_GLIDE  = 2'd1;
   localparam logic [1:0] MODE_HOLD   = 2'd2;

   function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
      min12 = (a < b) ? a : b;
   endfunction

   // Returns {dir, pos}; dir=1 means moving left/up. Zero speed leaves the axis untouched.
   function automatic logic [12:0] bounce_axis(input logic [11:0] pos, input logic dir,
                                               input logic [3:0] speed, input logic [11:0] lim);
      logic [11:0] sp;
      sp = {8'd0, speed};
      bounce_axis = {dir, pos};
      if (speed != 4'd0) begin
         if (!dir) begin
            if (pos + sp >= lim) bounce_axis = {1'b1, lim};
            else                 bounce_axis = {1'b0, pos + sp};
         end else begin
            if (pos < sp)        bounce_axis = {1'b0, 12'd0};
            else                 bounce_axis = {1'b1, pos - sp};
         end
      end
   endfunction

   function automatic logic [11:0] glide_step(input logic [11:0] pos, input logic [11:0] tgt,
                                              input logic [3:0] step);
      logic [11:0] st;
      st = {8'd0, step};
      if (tgt >= pos) glide_step = pos + min12(tgt - pos, st);
      else            glide_step = pos - min12(pos - tgt, st);
   endfunction

endpackage

// File: rtl/blob_motion_ctrl_frame_tick.sv
// Registered one-cycle frame tick, one cycle after the first pixel of line TICK_LINE.
// Latency 1 cycle; no flow control.
module frame_tick_gen
   import blob_motion_ctrl_pkg::*;
#(
   parameter int TICK_LINE = SCREEN_H
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic        tick
);

   always_ff @(posedge clk) begin
      if (reset) tick <= 1'b0;
      else       tick <= (hcount == 11'd0) && (vcount == 10'(TICK_LINE));
   end

endmodule

// File: rtl/blob_motion_ctrl.sv
// Per-sprite position generator: bounce, glide to an accepted target, hold on arrival.
// x/y change 1 cycle after the frame tick; target_ready drops only while gliding.
module blob_motion_ctrl
   import blob_motion_ctrl_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int HEIGHT   = 64,
   parameter int SCREEN_W = blob_motion_ctrl_pkg::SCREEN_W,
   parameter int SCREEN_H = blob_motion_ctrl_pkg::SCREEN_H,
   parameter int STEP     = 4,
   parameter int INIT_X   = 0,
   parameter int INIT_Y   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [3:0]  hspeed,
   input  logic [3:0]  vspeed,
   input  logic        pause,
   input  logic        resume,
   input  logic [10:0] target_x,
   input  logic [9:0]  target_y,
   input  logic        target_valid,
   output logic        target_ready,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        arrived,
   output logic [1:0]  mode
);

   localparam logic [11:0] XMAX   = 12'(SCREEN_W - WIDTH);
   localparam logic [11:0] YMAX   = 12'(SCREEN_H - HEIGHT);
   localparam logic [3:0]  STEP_V = 4'(STEP);

   logic        tick;
   logic        accept;
   logic        move;
   logic [11:0] pos_x, pos_y, tgt_x, tgt_y;
   logic        dir_x, dir_y;
   logic [12:0] bnc_x, bnc_y;
   logic [11:0] gld_x, gld_y;

   frame_tick_gen #(.TICK_LINE(SCREEN_H)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .hcount (hcount),
      .vcount (vcount),
      .tick   (tick)
   );

   assign target_ready = (mode != MODE_GLIDE);
   assign accept       = target_valid && target_ready;
   // An accept steals the tick so the new glide starts from a clean frame.
   assign move         = tick && !pause && !accept;

   assign bnc_x = bounce_axis(pos_x, dir_x, hspeed, XMAX);
   assign bnc_y = bounce_axis(pos_y, dir_y, vspeed, YMAX);
   assign gld_x = glide_step(pos_x, tgt_x, STEP_V);
   assign gld_y = glide_step(pos_y, tgt_y, STEP_V);

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_x   <= 12'(INIT_X);
         pos_y   <= 12'(INIT_Y);
         dir_x   <= 1'b0;
         dir_y   <= 1'b0;
         tgt_x   <= 12'd0;
         tgt_y   <= 12'd0;
         mode    <= MODE_BOUNCE;
         arrived <= 1'b0;
      end else begin
         arrived <= 1'b0;
         if (accept) begin
            tgt_x <= min12({1'b0, target_x}, XMAX);
            tgt_y <= min12({2'b0, target_y}, YMAX);
            mode  <= MODE_GLIDE;
         end else begin
            case (mode)
               MODE_BOUNCE: if (move) begin
                  {dir_x, pos_x} <= bnc_x;
                  {dir_y, pos_y} <= bnc_y;
               end
               MODE_GLIDE: if (move) begin
                  pos_x <= gld_x;
                  pos_y <= gld_y;
                  if (gld_x == tgt_x && gld_y == tgt_y) begin
                     mode    <= MODE_HOLD;
                     arrived <= 1'b1;
                  end
               end
               MODE_HOLD: if (resume) mode <= MODE_BOUNCE;
               default:   mode <= MODE_BOUNCE;
            endcase
         end
      end
   end

   assign x = pos_x[10:0];
   assign y = pos_y[9:0];

endmodule

// File: tb/tb_blob_motion_ctrl.sv
// Scoreboard bench for blob_motion_ctrl with default parameters.
module tb_blob_motion_ctrl;

   localparam int XMAX = 960;
   localparam int YMAX = 704;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  hspeed, vspeed;
   logic        pause, resume;
   logic [10:0] target_x;
   logic [9:0]  target_y;
   logic        target_valid;
   logic        target_ready;
   logic [10:0] x;
   logic [9:0]  y;
   logic        arrived;
   logic [1:0]  mode;

   always #5 clk = ~clk;

   blob_motion_ctrl dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .hspeed(hspeed), .vspeed(vspeed), .pause(pause), .resume(resume),
      .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
      .target_ready(target_ready), .x(x), .y(y), .arrived(arrived), .mode(mode)
   );

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic [1:0]  mode;
      logic        arr;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0;
   int arrived_cnt = 0, tick_cnt = 0;
   int mx, my, mdx, mdy, mmode, mtx, mty, marr;

   always @(negedge clk) begin
      if (arrived === 1'b1) arrived_cnt++;
      if (dut.tick === 1'b1) tick_cnt++;
   end

   task automatic model_reset();
      mx = 0; my = 0; mdx = 0; mdy = 0; mmode = 0; mtx = 0; mty = 0; marr = 0;
   endtask

   task automatic model_tick();
      int hs, vs;
      hs = int'(hspeed); vs = int'(vspeed); marr = 0;
      if (pause) return;
      if (mmode == 0) begin
         if (hs != 0) begin
            if (mdx == 0) begin
               if (mx + hs >= XMAX) begin mx = XMAX; mdx = 1; end else mx = mx + hs;
            end else begin
               if (mx < hs) begin mx = 0; mdx = 0; end else mx = mx - hs;
            end
         end
         if (vs != 0) begin
            if (mdy == 0) begin
               if (my + vs >= YMAX) begin my = YMAX; mdy = 1; end else my = my + vs;
            end else begin
               if (my < vs) begin my = 0; mdy = 0; end else my = my - vs;
            end
         end
      end else if (mmode == 1) begin
         if (mtx > mx) mx = mx + ((mtx - mx > STEP) ? STEP : mtx - mx);
         else          mx = mx - ((mx - mtx > STEP) ? STEP : mx - mtx);
         if (mty > my) my = my + ((mty - my > STEP) ? STEP : mty - my);
         else          my = my - ((my - mty > STEP) ? STEP : my - mty);
         if (mx == mtx && my == mty) begin mmode = 2; marr = 1; end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         hcount = 11'($urandom_range(1, 1300));
         vcount = 10'($urandom_range(0, 805));
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; target_valid = 1'b0; resume = 1'b0; pause = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_frame();
      exp_t e, got;
      @(negedge clk);
      hcount = 11'd0; vcount = 10'd768;
      model_tick();
      e.x = mx[10:0]; e.y = my[9:0]; e.mode = mmode[1:0]; e.arr = marr[0];
      q.push_back(e);
      checks++;
      if (dut.tick !== 1'b0) begin errors++; $display("FAIL tick_early got %b want 0", dut.tick); end
      @(negedge clk);
      hcount = 11'd37; vcount = 10'd769;
      checks++;
      if (dut.tick !== 1'b1) begin errors++; $display("FAIL tick_missing got %b want 1", dut.tick); end
      @(negedge clk);
      checks++;
      if (dut.tick !== 1'b0) begin errors++; $display("FAIL tick_long got %b want 0", dut.tick); end
      got = '{x, y, mode, arrived};
      e = q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL frame got x=%0d y=%0d mode=%0d arr=%b want x=%0d y=%0d mode=%0d arr=%b",
                  got.x, got.y, got.mode, got.arr, e.x, e.y, e.mode, e.arr);
      end
      idle(2);
   endtask

   task automatic offer(input logic [10:0] tx, input logic [9:0] ty, input logic exp_ready);
      @(negedge clk);
      target_x = tx; target_y = ty; target_valid = 1'b1;
      checks++;
      if (target_ready !== exp_ready) begin
         errors++; $display("FAIL offer_ready got %b want %b", target_ready, exp_ready);
      end
      @(negedge clk);
      target_valid = 1'b0;
      if (exp_ready) begin
         mtx = (int'(tx) > XMAX) ? XMAX : int'(tx);
         mty = (int'(ty) > YMAX) ? YMAX : int'(ty);
         mmode = 1;
      end
      checks++;
      if (mode !== mmode[1:0]) begin errors++; $display("FAIL offer_mode got %0d want %0d", mode, mmode); end
   endtask

   task automatic glide_until_hold(input int bound);
      for (int i = 0; i < bound && mode !== 2'd2; i++) begin
         do_frame();
         checks++;
         if (x > 11'(XMAX) || y > 10'(YMAX)) begin
            errors++; $display("FAIL bounds got x=%0d y=%0d want <=%0d,<=%0d", x, y, XMAX, YMAX);
         end
      end
      checks++;
      if (mode !== 2'd2) begin errors++; $display("FAIL glide_timeout got mode=%0d want 2", mode); end
   endtask

   task automatic test_reset();
      reset = 1'b1; hcount = 11'd100; vcount = 10'd100; hspeed = 4'd0; vspeed = 4'd0;
      pause = 1'b0; resume = 1'b0; target_x = '0; target_y = '0; target_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks += 5;
      if (x !== 11'd0)         begin errors++; $display("FAIL reset_x got %0d want 0", x); end
      if (y !== 10'd0)         begin errors++; $display("FAIL reset_y got %0d want 0", y); end
      if (mode !== 2'd0)       begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
      if (target_ready !== 1)  begin errors++; $display("FAIL reset_ready got %b want 1", target_ready); end
      if (arrived !== 0)       begin errors++; $display("FAIL reset_arrived got %b want 0", arrived); end
   endtask

   task automatic test_bounce();
      int t0;
      apply_reset();
      hspeed = 4'd3; vspeed = 4'd2; arrived_cnt = 0; t0 = tick_cnt;
      repeat (3) do_frame();
      checks += 5;
      if (x !== 11'd9)        begin errors++; $display("FAIL bounce_x got %0d want 9", x); end
      if (y !== 10'd6)        begin errors++; $display("FAIL bounce_y got %0d want 6", y); end
      if (target_ready !== 1) begin errors++; $display("FAIL bounce_ready got %b want 1", target_ready); end
      if (arrived_cnt != 0)   begin errors++; $display("FAIL bounce_arrived got %0d want 0", arrived_cnt); end
      if (tick_cnt - t0 != 3) begin errors++; $display("FAIL bounce_ticks got %0d want 3", tick_cnt - t0); end
   endtask

   task automatic test_glide();
      apply_reset();
      hspeed = 4'd0; vspeed = 4'd0; arrived_cnt = 0;
      offer(11'd10, 10'd3, 1'b1);
      do_frame();
      checks++;
      if (x !== 11'd4 || y !== 10'd3) begin errors++; $display("FAIL glide_t1 got %0d,%0d want 4,3", x, y); end
      do_frame();
      checks++;
      if (x !== 11'd8 || y !== 10'd3) begin errors++; $display("FAIL glide_t2 got %0d,%0d want 8,3", x, y); end
      do_frame();
      checks += 4;
      if (x !== 11'd10 || y !== 10'd3) begin errors++; $display("FAIL glide_t3 got %0d,%0d want 10,3", x, y); end
      if (mode !== 2'd2)      begin errors++; $display("FAIL glide_mode got %0d want 2", mode); end
      if (target_ready !== 1) begin errors++; $display("FAIL glide_ready got %b want 1", target_ready); end
      if (arrived_cnt != 1)   begin errors++; $display("FAIL glide_arrived got %0d want 1", arrived_cnt); end
   endtask

   task automatic test_resume();
      apply_reset();
      hspeed = 4'd0; vspeed = 4'd0;
      offer(11'd958, 10'd100, 1'b1);
      glide_until_hold(300);
      checks++;
      if (x !== 11'd958 || y !== 10'd100) begin errors++; $display("FAIL resume_start got %0d,%0d want 958,100", x, y); end
      @(negedge clk);
      hspeed = 4'd4; vspeed = 4'd0; resume = 1'b1;
      @(negedge clk);
      resume = 1'b0; mmode = 0;
      checks++;
      if (mode !== 2'd0) begin errors++; $display("FAIL resume_mode got %0d want 0", mode); end
      do_frame();
      checks++;
      if (x !== 11'd960) begin errors++; $display("FAIL resume_wall got %0d want 960", x); end
      do_frame();
      do_frame();
      checks += 2;
      if (x !== 11'd952) begin errors++; $display("FAIL resume_left got %0d want 952", x); end
      if (y !== 10'd100) begin errors++; $display("FAIL resume_y got %0d want 100", y); end
   endtask

   task automatic test_clamp();
      apply_reset();
      offer(11'd2000, 10'd900, 1'b1);
      glide_until_hold(300);
      checks++;
      if (x !== 11'd960 || y !== 10'd704) begin errors++; $display("FAIL clamp got %0d,%0d want 960,704", x, y); end
      offer(11'd5, 10'd5, 1'b1);
   endtask

   task automatic test_pause();
      apply_reset();
      hspeed = 4'd5; vspeed = 4'd5; pause = 1'b1;
      repeat (5) do_frame();
      checks++;
      if (x !== 11'd0 || y !== 10'd0) begin errors++; $display("FAIL pause_bounce got %0d,%0d want 0,0", x, y); end
      offer(11'd20, 10'd20, 1'b1);
      repeat (2) do_frame();
      checks++;
      if (x !== 11'd0 || y !== 10'd0) begin errors++; $display("FAIL pause_glide got %0d,%0d want 0,0", x, y); end
      pause = 1'b0;
      do_frame();
      checks++;
      if (x !== 11'd4 || y !== 10'd4) begin errors++; $display("FAIL pause_release got %0d,%0d want 4,4", x, y); end
   endtask

   task automatic test_reset_mid_glide();
      apply_reset();
      hspeed = 4'd0; vspeed = 4'd0;
      offer(11'd100, 10'd50, 1'b1);
      repeat (2) do_frame();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks += 5;
      if (x !== 11'd0 || y !== 10'd0) begin errors++; $display("FAIL midrst_pos got %0d,%0d want 0,0", x, y); end
      if (mode !== 2'd0)      begin errors++; $display("FAIL midrst_mode got %0d want 0", mode); end
      if (target_ready !== 1) begin errors++; $display("FAIL midrst_ready got %b want 1", target_ready); end
      if (arrived !== 0)      begin errors++; $display("FAIL midrst_arrived got %b want 0", arrived); end
      do_frame();
      if (mode !== 2'd0)      begin errors++; $display("FAIL midrst_discard got mode=%0d want 0", mode); end
   endtask

   task automatic test_accept_on_tick();
      apply_reset();
      hspeed = 4'd3; vspeed = 4'd2;
      @(negedge clk);
      hcount = 11'd0; vcount = 10'd768;
      @(negedge clk);
      hcount = 11'd37; vcount = 10'd769;
      target_x = 11'd10; target_y = 10'd10; target_valid = 1'b1;
      checks++;
      if (dut.tick !== 1'b1 || target_ready !== 1'b1) begin
         errors++; $display("FAIL aot_setup got tick=%b ready=%b want 1,1", dut.tick, target_ready);
      end
      @(negedge clk);
      target_valid = 1'b0;
      mtx = 10; mty = 10; mmode = 1;
      checks++;
      if (x !== 11'd0 || y !== 10'd0 || mode !== 2'd1) begin
         errors++; $display("FAIL aot_drop got %0d,%0d mode=%0d want 0,0 mode=1", x, y, mode);
      end
      idle(2);
      do_frame();
      checks++;
      if (x !== 11'd4 || y !== 10'd4) begin errors++; $display("FAIL aot_next got %0d,%0d want 4,4", x, y); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_glide();
      test_resume();
      test_clamp();
      test_pause();
      test_reset_mid_glide();
      test_accept_on_tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
